data_move_mc: RTL and testbench

- Parametrised successor of the single-byte-burst mover; copies a 1..2^LEN_W byte block from one source area to one destination area per command.
- Sits between the 6-byte command decoder and the local/cross/remote buffers, AFPGA and console memories.
- Adds a valid/ready command handshake, error status, configurable read latency, area count and area permission masks, and per-area base offsets.

---
 rtl/data_move_pkg.sv | 28 ++
 rtl/data_move_rdpipe.sv | 53 +++++
 rtl/data_move_mc.sv | 193 +++++++++++++++++++
 tb/tb_data_move_mc.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_move_pkg.sv
// Shared types and constants for the multi-byte area-to-area data mover.
package data_move_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_SRC   = 2'd1;
  localparam logic [1:0] ERR_DST   = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;

  // Default area assignment of the surrounding system.
  localparam int unsigned LB_RX   = 0;
  localparam int unsigned LB_TX   = 1;
  localparam int unsigned CB_RX   = 2;
  localparam int unsigned CB_TX   = 3;
  localparam int unsigned RB_RX   = 4;
  localparam int unsigned RB_TX   = 5;
  localparam int unsigned AFPGA_0 = 6;
  localparam int unsigned AFPGA_1 = 7;
  localparam int unsigned CONS_WR = 8;
  localparam int unsigned CONS_RD = 9;

endpackage

// File: rtl/data_move_rdpipe.sv
// Read-latency tracker: RD_LAT-deep valid/area shift register, source lane
// select and a registered output byte that drives the write port.
module data_move_rdpipe #(
  parameter int unsigned NUM_AREA = 10,
  parameter int unsigned AREA_W   = 4,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_i,
  input  logic [AREA_W-1:0]     area_i,
  input  logic [NUM_AREA*8-1:0] rd_data_i,
  output logic                  pending_o,
  output logic                  valid_o,
  output logic [7:0]            data_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [AREA_W-1:0] area_q [RD_LAT];
  logic              out_vld_q;
  logic [7:0]        out_data_q;
  logic [7:0]        lane;

  always_comb begin
    lane = '0;
    for (int unsigned i = 0; i < NUM_AREA; i++) begin
      if (area_q[RD_LAT-1] == AREA_W'(i)) lane = rd_data_i[i*8 +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q      <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) area_q[i] <= '0;
    end else begin
      vld_q[0]  <= issue_i;
      area_q[0] <= area_i;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        area_q[i] <= area_q[i-1];
      end
      out_vld_q  <= vld_q[RD_LAT-1];
      out_data_q <= vld_q[RD_LAT-1] ? lane : '0;
    end
  end

  assign pending_o = |vld_q;
  assign valid_o   = out_vld_q;
  assign data_o    = out_data_q;

endmodule

// File: rtl/data_move_mc.sv
// Block copy engine between memory areas with valid/ready command intake and
// error status. Optional checksum output enabled by DATA_MOVE_CSUM_EN.
module data_move_mc
  import data_move_pkg::*;
#(
  parameter int unsigned NUM_AREA = 10,
  parameter int unsigned AREA_W   = 4,
  parameter int unsigned ADDR_W   = 23,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned RD_LAT   = 2,
  parameter logic [NUM_AREA-1:0]        SRC_MASK = 10'b1011010101,
  parameter logic [NUM_AREA-1:0]        DST_MASK = 10'b0111101010,
  parameter logic [NUM_AREA*ADDR_W-1:0] AREA_OFS =
    {{2{23'h0}}, {2{23'h100000}}, {6{23'h0}}}
) (
  input  logic                  sys_clk_50m,
  input  logic                  sys_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AREA_W-1:0]     cmd_src_area,
  input  logic [15:0]           cmd_src_addr,
  input  logic [AREA_W-1:0]     cmd_dst_area,
  input  logic [15:0]           cmd_dst_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic [NUM_AREA-1:0]   rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [NUM_AREA*8-1:0] rd_data,
  output logic [NUM_AREA-1:0]   wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  move_done,
  output logic [1:0]            move_err
`ifdef DATA_MOVE_CSUM_EN
  ,
  output logic [7:0]            move_csum
`endif
);

  state_e            state_q, state_d;
  logic [AREA_W-1:0] src_area_q, src_area_d, dst_area_q, dst_area_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]  rd_left_q, rd_left_d, wr_left_q, wr_left_d;
  logic [1:0]        err_q, err_d;

  logic              src_ok, dst_ok, range_ok;
  logic [ADDR_W-1:0] src_ofs, dst_ofs;
  logic [ADDR_W+1:0] src_base_w, dst_base_w, src_end, dst_end;
  logic [1:0]        err_chk;
  logic              accept, issue, wr_fire, pipe_pending;
  logic [7:0]        pipe_data;

  // Command checks use the live command fields so the verdict is ready at accept.
  always_comb begin
    src_ok  = 1'b0;
    dst_ok  = 1'b0;
    src_ofs = '0;
    dst_ofs = '0;
    for (int unsigned i = 0; i < NUM_AREA; i++) begin
      if (cmd_src_area == AREA_W'(i)) begin
        src_ok  = SRC_MASK[i];
        src_ofs = AREA_OFS[i*ADDR_W +: ADDR_W];
      end
      if (cmd_dst_area == AREA_W'(i)) begin
        dst_ok  = DST_MASK[i];
        dst_ofs = AREA_OFS[i*ADDR_W +: ADDR_W];
      end
    end
    src_base_w = (ADDR_W+2)'(cmd_src_addr) + (ADDR_W+2)'(src_ofs);
    dst_base_w = (ADDR_W+2)'(cmd_dst_addr) + (ADDR_W+2)'(dst_ofs);
    src_end    = src_base_w + (ADDR_W+2)'(cmd_len);
    dst_end    = dst_base_w + (ADDR_W+2)'(cmd_len);
    range_ok   = ((src_end >> ADDR_W) == '0) && ((dst_end >> ADDR_W) == '0);
    if (!src_ok)        err_chk = ERR_SRC;
    else if (!dst_ok)   err_chk = ERR_DST;
    else if (!range_ok) err_chk = ERR_RANGE;
    else                err_chk = ERR_OK;
  end

  assign accept = (state_q == ST_IDLE) && cmd_valid;
  assign issue  = (state_q == ST_READ);

  always_comb begin
    state_d    = state_q;
    src_area_d = src_area_q;
    dst_area_d = dst_area_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    rd_left_d  = rd_left_q;
    wr_left_d  = wr_left_q;
    err_d      = err_q;
    if (wr_fire) begin
      wr_addr_d = wr_addr_q + 1'b1;
      wr_left_d = wr_left_q - 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          src_area_d = cmd_src_area;
          dst_area_d = cmd_dst_area;
          rd_addr_d  = src_base_w[ADDR_W-1:0];
          wr_addr_d  = dst_base_w[ADDR_W-1:0];
          rd_left_d  = cmd_len;
          wr_left_d  = cmd_len;
          err_d      = err_chk;
          state_d    = (err_chk == ERR_OK) ? ST_READ : ST_DONE;
        end
      end
      ST_READ: begin
        rd_addr_d = rd_addr_q + 1'b1;
        if (rd_left_q == '0) state_d = ST_DRAIN;
        else                 rd_left_d = rd_left_q - 1'b1;
      end
      ST_DRAIN: begin
        if (wr_fire && (wr_left_q == '0) && !pipe_pending) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_50m) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      src_area_q <= '0;
      dst_area_q <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      rd_left_q  <= '0;
      wr_left_q  <= '0;
      err_q      <= ERR_OK;
    end else begin
      state_q    <= state_d;
      src_area_q <= src_area_d;
      dst_area_q <= dst_area_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      rd_left_q  <= rd_left_d;
      wr_left_q  <= wr_left_d;
      err_q      <= err_d;
    end
  end

  data_move_rdpipe #(
    .NUM_AREA (NUM_AREA),
    .AREA_W   (AREA_W),
    .RD_LAT   (RD_LAT)
  ) u_rdpipe (
    .clk_i     (sys_clk_50m),
    .rst_i     (sys_rst),
    .issue_i   (issue),
    .area_i    (src_area_q),
    .rd_data_i (rd_data),
    .pending_o (pipe_pending),
    .valid_o   (wr_fire),
    .data_o    (pipe_data)
  );

  always_comb begin
    rd_en = '0;
    wr_en = '0;
    for (int unsigned i = 0; i < NUM_AREA; i++) begin
      if (src_area_q == AREA_W'(i)) rd_en[i] = issue;
      if (dst_area_q == AREA_W'(i)) wr_en[i] = wr_fire;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign move_done = (state_q == ST_DONE);
  assign move_err  = move_done ? err_q : ERR_OK;
  assign rd_addr   = issue ? rd_addr_q : '0;
  assign wr_addr   = wr_fire ? wr_addr_q : '0;
  assign wr_data   = pipe_data;

`ifdef DATA_MOVE_CSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (accept)       csum_d = '0;
    else if (wr_fire) csum_d = csum_q + pipe_data;
  end

  always_ff @(posedge sys_clk_50m) begin
    if (sys_rst) csum_q <= '0;
    else         csum_q <= csum_d;
  end

  assign move_csum = move_done ? csum_q : '0;
`endif

endmodule

// File: tb/tb_data_move_mc.sv
// Self-checking bench for data_move_mc: per-cycle comparison against a
// command-level model plus directed literal checks.
module tb_data_move_mc;

  localparam int unsigned NUM_AREA = 10;
  localparam int unsigned RD_LAT   = 2;
  localparam logic [9:0]  SRC_M    = 10'b1011010101;
  localparam logic [9:0]  DST_M    = 10'b0111101010;

  logic        clk;
  logic        sys_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_src_area;
  logic [15:0] cmd_src_addr;
  logic [3:0]  cmd_dst_area;
  logic [15:0] cmd_dst_addr;
  logic [7:0]  cmd_len;
  logic [9:0]  rd_en;
  logic [22:0] rd_addr;
  logic [79:0] rd_data;
  logic [9:0]  wr_en;
  logic [22:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        move_done;
  logic [1:0]  move_err;
`ifdef DATA_MOVE_CSUM_EN
  logic [7:0]  move_csum;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int slot    = 0;
  bit started = 0;

  data_move_mc #(
    .NUM_AREA (10),
    .AREA_W   (4),
    .ADDR_W   (23),
    .LEN_W    (8),
    .RD_LAT   (RD_LAT),
    .SRC_MASK (SRC_M),
    .DST_MASK (DST_M),
    .AREA_OFS ({{2{23'h0}}, 23'h7FFF80, 23'h100000, {6{23'h0}}})
  ) dut (
    .sys_clk_50m  (clk),
    .sys_rst      (sys_rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_src_area (cmd_src_area),
    .cmd_src_addr (cmd_src_addr),
    .cmd_dst_area (cmd_dst_area),
    .cmd_dst_addr (cmd_dst_addr),
    .cmd_len      (cmd_len),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .move_done    (move_done),
    .move_err     (move_err)
`ifdef DATA_MOVE_CSUM_EN
    ,
    .move_csum    (move_csum)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    slot++;
  end

  function automatic int ofs(input int a);
    case (a)
      6:       return 'h100000;
      7:       return 'h7FFF80;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] mem_byte(input int a, input logic [22:0] addr);
    if (a == 0 && addr >= 23'h300 && addr <= 23'h302) begin
      case (addr[1:0])
        2'd0:    return 8'h80;
        2'd1:    return 8'h90;
        default: return 8'h10;
      endcase
    end
    return 8'(addr ^ (addr >> 8) ^ (addr >> 16)) + 8'(a * 37 + 11);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (slot %0d)", name, act, exp, slot);
    end
  endtask

  // Area memories: a read strobed in cycle c returns its byte RD_LAT cycles later.
  initial begin : mem_drv
    logic [9:0]  h_en   [RD_LAT];
    logic [22:0] h_addr [RD_LAT];
    logic [9:0]  cur_en;
    logic [22:0] cur_addr;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      h_en[i]   = '0;
      h_addr[i] = '0;
    end
    rd_data = '0;
    forever begin
      @(negedge clk);
      cur_en   = rd_en;
      cur_addr = rd_addr;
      @(posedge clk);
      #1;
      for (int unsigned i = RD_LAT - 1; i > 0; i--) begin
        h_en[i]   = h_en[i-1];
        h_addr[i] = h_addr[i-1];
      end
      h_en[0]   = cur_en;
      h_addr[0] = cur_addr;
      for (int unsigned a = 0; a < NUM_AREA; a++) begin
        if (h_en[RD_LAT-1][a] === 1'b1) rd_data[a*8 +: 8] = mem_byte(int'(a), h_addr[RD_LAT-1]);
        else                            rd_data[a*8 +: 8] = 8'($urandom);
      end
    end
  end

  // Command-level model: one active move, outputs derived from cycle offset.
  bit         m_active = 0;
  int         m_t, m_src, m_dst, m_sbase, m_dbase, m_len, m_err, m_done_d;
  logic [7:0] m_csum;

  task automatic model_accept();
    m_active = 1;
    m_t      = slot;
    m_src    = int'(cmd_src_area);
    m_dst    = int'(cmd_dst_area);
    m_len    = int'(cmd_len);
    m_sbase  = int'(cmd_src_addr) + ofs(m_src);
    m_dbase  = int'(cmd_dst_addr) + ofs(m_dst);
    if (!((m_src < 10) ? SRC_M[m_src] : 1'b0))      m_err = 1;
    else if (!((m_dst < 10) ? DST_M[m_dst] : 1'b0)) m_err = 2;
    else if (m_sbase + m_len > 'h7FFFFF || m_dbase + m_len > 'h7FFFFF) m_err = 3;
    else m_err = 0;
    m_done_d = (m_err != 0) ? 1 : 3 + RD_LAT + m_len;
    m_csum   = 8'h00;
    if (m_err == 0)
      for (int unsigned k = 0; k <= m_len; k++) m_csum += mem_byte(m_src, 23'(m_sbase + int'(k)));
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (started) begin
        int d, k;
        logic [9:0]  e_rd_en, e_wr_en;
        logic [22:0] e_rd_addr, e_wr_addr;
        logic [7:0]  e_wr_data, e_csum;
        logic        e_busy, e_ready, e_done;
        logic [1:0]  e_err;
        e_ready = !m_active; e_busy = 1'b0; e_done = 1'b0; e_err = '0; e_csum = '0;
        e_rd_en = '0; e_rd_addr = '0; e_wr_en = '0; e_wr_addr = '0; e_wr_data = '0;
        if (m_active) begin
          d = slot - m_t;
          e_busy = (d != m_done_d);
          if (m_err == 0 && d >= 1 && d <= m_len + 1) begin
            e_rd_en   = 10'(1) << m_src;
            e_rd_addr = 23'(m_sbase + d - 1);
          end
          if (m_err == 0 && d >= 2 + RD_LAT && d <= 2 + RD_LAT + m_len) begin
            k         = d - 2 - RD_LAT;
            e_wr_en   = 10'(1) << m_dst;
            e_wr_addr = 23'(m_dbase + k);
            e_wr_data = mem_byte(m_src, 23'(m_sbase + k));
          end
          if (d == m_done_d) begin
            e_done = 1'b1;
            e_err  = 2'(m_err);
            e_csum = m_csum;
          end
        end
        check("cmd_ready", 64'(cmd_ready), 64'(e_ready));
        check("busy",      64'(busy),      64'(e_busy));
        check("rd_en",     64'(rd_en),     64'(e_rd_en));
        check("rd_addr",   64'(rd_addr),   64'(e_rd_addr));
        check("wr_en",     64'(wr_en),     64'(e_wr_en));
        check("wr_addr",   64'(wr_addr),   64'(e_wr_addr));
        check("wr_data",   64'(wr_data),   64'(e_wr_data));
        check("move_done", 64'(move_done), 64'(e_done));
        check("move_err",  64'(move_err),  64'(e_err));
`ifdef DATA_MOVE_CSUM_EN
        check("move_csum", 64'(move_csum), 64'(e_csum));
`endif
        if (sys_rst)                                    m_active = 0;
        else if (m_active && slot - m_t == m_done_d)    m_active = 0;
        else if (!m_active && cmd_valid && cmd_ready)   model_accept();
      end
    end
  end

  task automatic send(input int s, input int sa, input int ds, input int da, input int l,
                      output int acc);
    @(posedge clk);
    #1;
    cmd_src_area = 4'(s);
    cmd_src_addr = 16'(sa);
    cmd_dst_area = 4'(ds);
    cmd_dst_addr = 16'(da);
    cmd_len      = 8'(l);
    cmd_valid    = 1'b1;
    acc = -1;
    for (int unsigned i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = slot;
        break;
      end
    end
    if (acc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no cmd_ready expected accept within 2000 cycles");
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int unsigned i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy expected idle within 2000 cycles");
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin : stim
    int t1, t2, s, ds;
    sys_rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_src_area = '0; cmd_src_addr = '0; cmd_dst_area = '0; cmd_dst_addr = '0; cmd_len = '0;
    repeat (3) @(posedge clk);
    #1;
    started = 1;
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(move_done), 64'd0);
    @(posedge clk);
    #1;
    sys_rst = 1'b0;

    // Short ok move: src 0 @0x10 -> dst 1 @0x20, four bytes.
    send(0, 'h10, 1, 'h20, 3, t1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t1_rd_en",   64'(rd_en),   64'h001);
    check("t1_rd_addr", 64'(rd_addr), 64'h10);
    repeat (3) @(negedge clk);
    check("t1_wr_en",   64'(wr_en),   64'h002);
    check("t1_wr_addr", 64'(wr_addr), 64'h20);
    repeat (4) @(negedge clk);
    check("t1_done",    64'(move_done), 64'd1);
    check("t1_err",     64'(move_err),  64'd0);
    wait_idle();

    // Area offset applied to source address.
    send(6, 0, 1, 'h40, 0, t1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("ofs_rd_addr", 64'(rd_addr), 64'h100000);
    check("ofs_rd_en",   64'(rd_en),   64'h040);
    wait_idle();

    // Error commands complete one cycle after accept with no strobes.
    send(1, 0, 3, 0, 4, t1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("e1_done", 64'(move_done), 64'd1);
    check("e1_err",  64'(move_err),  64'd1);
    check("e1_strb", 64'({rd_en, wr_en}), 64'd0);
    send(0, 0, 9, 0, 4, t1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("e2_done", 64'(move_done), 64'd1);
    check("e2_err",  64'(move_err),  64'd2);
    send(7, 'h80, 1, 0, 0, t1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("e3_done", 64'(move_done), 64'd1);
    check("e3_err",  64'(move_err),  64'd3);
    check("e3_strb", 64'({rd_en, wr_en}), 64'd0);
    wait_idle();

    // Back-to-back: second command held until after the done cycle.
    send(0, 'h100, 3, 'h200, 5, t1);
    send(2, 'h50, 5, 'h60, 2, t2);
    cmd_valid = 1'b0;
    check("b2b_gap", 64'(t2 - t1), 64'd11);
    wait_idle();

`ifdef DATA_MOVE_CSUM_EN
    send(0, 'h300, 1, 'h10, 2, t1);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("csum_done",  64'(move_done), 64'd1);
    check("csum_value", 64'(move_csum), 64'h20);
    wait_idle();
`endif

    // Reset during DRAIN of a 16-byte move.
    send(0, 'h500, 1, 'h600, 15, t1);
    cmd_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    sys_rst = 1'b1;
    @(posedge clk);
    #1;
    sys_rst = 1'b0;
    @(negedge clk);
    check("rst_mid_strb",  64'({rd_en, wr_en}), 64'd0);
    check("rst_mid_busy",  64'(busy),      64'd0);
    check("rst_mid_ready", 64'(cmd_ready), 64'd1);
    check("rst_mid_done",  64'(move_done), 64'd0);
    @(negedge clk);
    check("rst_mid_done2", 64'(move_done), 64'd0);

    // Random commands, mostly legal, with random gaps and back-to-back runs.
    for (int unsigned n = 0; n < 200; n++) begin
      int sel, l, gap;
      int rd_list [6] = '{0, 2, 4, 6, 7, 9};
      int wr_list [6] = '{1, 3, 5, 6, 7, 8};
      sel = int'($urandom_range(0, 5));
      s   = ($urandom_range(0, 3) != 0) ? rd_list[sel] : int'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 5));
      ds  = ($urandom_range(0, 3) != 0) ? wr_list[sel] : int'($urandom_range(0, 15));
      gap = int'($urandom_range(0, 19));
      if (gap < 14)      l = int'($urandom_range(0, 15));
      else if (gap < 19) l = int'($urandom_range(16, 63));
      else               l = int'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 3));
      if (gap != 0) begin
        cmd_valid = 1'b0;
        repeat (gap) @(posedge clk);
      end
      send(s, int'($urandom_range(0, 65535)), ds, int'($urandom_range(0, 65535)), l, t1);
    end
    cmd_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
